// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues word fetches, tags each request with its PC,
// buffers returned words in a small FIFO and hands one instruction per cycle to IF/ID.
// Redirects flush the queue and drop any responses still in flight for the old path.
module fetch_prefetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4,
  output logic [2:0]  DEBUG_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = 2;  // holds 0..3 in-flight requests
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        q_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // outstanding counts every unanswered request, including those destined to be dropped
  logic [OW-1:0] outstanding, discard;
  logic [31:0]   fetch_pc;

  logic [31:0]   tag_mem [MAX_OUTSTANDING];
  logic [TW-1:0] tag_wr, tag_rd;

  logic          issue, push, pop, full;
  logic [31:0]   redirect_aligned;
  entry_t        head;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  assign redirect_aligned = redirect_pc & ~32'h3;

  // Credit check: a slot is reserved for every request in flight, so a response never finds the queue full.
  assign issue = !reset && !redirect
               && ((int'(count) + int'(outstanding)) < DEPTH)
               && (int'(outstanding) < MAX_OUTSTANDING);
  assign push  = imem_rvalid && (discard == '0) && !redirect;
  assign pop   = out_valid && out_ready;
  assign full  = (count == CW'(DEPTH));

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc;
  assign out_valid   = (count != '0);
  assign DEBUG_count = 3'(count);

  // Head fields read straight from storage; zeroed while empty so idle outputs are deterministic.
  assign head          = q_mem[rd_ptr];
  assign out_instr     = out_valid ? head.instr : '0;
  assign out_pc        = out_valid ? head.pc : '0;
  assign out_pc_plus_4 = out_valid ? head.pc + 32'd4 : '0;

  // Fetch PC and the in-order PC tag pointers; tags pop on every response, dropped or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      if (redirect)   fetch_pc <= redirect_aligned;
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (issue)       tag_wr <= tag_next(tag_wr);
      if (imem_rvalid) tag_rd <= tag_next(tag_rd);
    end
  end

  // Tag storage: PC of each issued request, consumed in response order.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr] <= fetch_pc;
  end

  // In-flight request count and the number of stale responses still to be dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (issue && !imem_rvalid)      outstanding <= outstanding + OW'(1);
      else if (!issue && imem_rvalid) outstanding <= outstanding - OW'(1);
      // On redirect everything still in flight after this cycle belongs to the old path.
      if (redirect)                            discard <= outstanding - OW'(imem_rvalid);
      else if (imem_rvalid && discard != '0)   discard <= discard - OW'(1);
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Queue storage write.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{instr: imem_rdata, pc: tag_mem[tag_rd]};
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: stimulus pushes expected PCs, a negedge
// monitor compares the queue head against the front of the expected stream.
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [2:0]  DEBUG_count;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int lat      = 1;
  bit mon_en   = 0;
  logic [31:0] exp_q[$];

  bit req_tab[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  int cnt_tab[10] = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};

  fetch_prefetch_queue dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4),
    .DEBUG_count(DEBUG_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: in-order responses, latency 1 or 2, reset together with the DUT.
  logic        mem_v1;
  logic [31:0] mem_a1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_rvalid <= 0; imem_rdata <= 0; mem_v1 <= 0; mem_a1 <= 0;
    end else begin
      mem_v1 <= imem_req;
      mem_a1 <= imem_addr;
      if (lat == 1) begin imem_rvalid <= imem_req; imem_rdata <= instr_of(imem_addr); end
      else          begin imem_rvalid <= mem_v1;   imem_rdata <= instr_of(mem_a1);    end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every visible head must match the expected stream; pops advance it.
  always @(negedge clk) begin
    if (mon_en && !reset && out_valid && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out actual_pc=%h required=none", out_pc);
      end else begin
        chk("head_pc", out_pc, exp_q[0]);
        chk("head_instr", out_instr, instr_of(exp_q[0]));
        chk("head_pc4", out_pc_plus_4, exp_q[0] + 32'd4);
        if (out_ready) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic do_reset(input int l, input logic rdy);
    mon_en = 0; reset = 1; redirect = 0; redirect_pc = 0;
    out_ready = rdy; lat = l; exp_q.delete(); pop_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic redir(input logic [31:0] pc, input logic [31:0] exp_start);
    redirect = 1; redirect_pc = pc;
    exp_q.delete();
    expect_seq(exp_start, 32);
  endtask

  task automatic cyc_clear();
    cyc(); redirect = 0;
  endtask

  initial begin
    reset = 1; redirect = 0; redirect_pc = 0; out_ready = 1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_count", DEBUG_count, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc4", out_pc_plus_4, 0);

    // Streaming, 1-cycle memory
    do_reset(1, 1);
    expect_seq(32'h0040_0000, 64);
    mon_en = 1;
    for (int i = 0; i < 20; i++) begin
      neg();
      chk("s_req", imem_req, 1);
      chk("s_addr", imem_addr, 32'h0040_0000 + 32'(4 * i));
      chk("s_valid", out_valid, (i >= 2) ? 1 : 0);
      cyc();
    end
    chk("s_pops", pop_cnt, 18);

    // Stall for 10 cycles, then drain
    do_reset(1, 0);
    expect_seq(32'h0040_0000, 64);
    mon_en = 1;
    for (int i = 0; i < 10; i++) begin
      neg();
      chk("st_req", imem_req, req_tab[i]);
      chk("st_count", DEBUG_count, cnt_tab[i]);
      cyc();
    end
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      neg();
      chk("dr_valid", out_valid, 1);
      cyc();
    end
    chk("dr_pops", pop_cnt, 10);

    // 2-cycle memory, redirect with two requests outstanding
    do_reset(2, 1);
    mon_en = 1;
    neg(); chk("r2_req0", imem_req, 1); chk("r2_addr0", imem_addr, 32'h0040_0000);
    cyc();
    neg(); chk("r2_req1", imem_req, 1); chk("r2_addr1", imem_addr, 32'h0040_0004);
    cyc();
    redir(32'h0040_0102, 32'h0040_0100);
    neg(); chk("r2_req_redir", imem_req, 0);
    cyc_clear();
    neg(); chk("r2_req3", imem_req, 1); chk("r2_addr3", imem_addr, 32'h0040_0100);
    chk("r2_v3", out_valid, 0);
    cyc();
    neg(); chk("r2_addr4", imem_addr, 32'h0040_0104); chk("r2_v4", out_valid, 0);
    cyc();
    neg(); chk("r2_v5", out_valid, 0);
    cyc();
    neg(); chk("r2_v6", out_valid, 1); chk("r2_pc6", out_pc, 32'h0040_0100);
    repeat (10) cyc();

    // Back-to-back redirects, 2-cycle memory
    do_reset(2, 1);
    mon_en = 1;
    cyc(); cyc();
    redir(32'h0040_0200, 32'h0040_0200);
    cyc();
    redir(32'h0040_0300, 32'h0040_0300);
    neg(); chk("bb_req_redir", imem_req, 0);
    cyc_clear();
    neg(); chk("bb_req", imem_req, 1); chk("bb_addr", imem_addr, 32'h0040_0300);
    cyc();
    neg(); chk("bb_v5", out_valid, 0);
    cyc();
    neg(); chk("bb_v6", out_valid, 0);
    cyc();
    neg(); chk("bb_v7", out_valid, 1); chk("bb_pc7", out_pc, 32'h0040_0300);
    repeat (6) cyc();

    // Redirect together with a response and a pop, 1-cycle memory
    do_reset(1, 1);
    expect_seq(32'h0040_0000, 64);
    mon_en = 1;
    repeat (4) cyc();
    neg(); chk("rp_pre_valid", out_valid, 1); chk("rp_pre_rvalid", imem_rvalid, 1);
    redir(32'h0040_0200, 32'h0040_0200);
    #1 chk("rp_req_redir", imem_req, 0);
    cyc_clear();
    neg(); chk("rp_count", DEBUG_count, 0); chk("rp_valid5", out_valid, 0);
    chk("rp_req5", imem_req, 1); chk("rp_addr5", imem_addr, 32'h0040_0200);
    cyc();
    neg(); chk("rp_valid6", out_valid, 0);
    cyc();
    neg(); chk("rp_valid7", out_valid, 1); chk("rp_pc7", out_pc, 32'h0040_0200);
    repeat (6) cyc();

    // Address wrap at 2^32
    do_reset(1, 1);
    mon_en = 1;
    redir(32'hFFFF_FFFE, 32'hFFFF_FFFC);
    neg(); chk("w_req_redir", imem_req, 0);
    cyc_clear();
    neg(); chk("w_addr1", imem_addr, 32'hFFFF_FFFC);
    cyc();
    neg(); chk("w_addr2", imem_addr, 32'h0000_0000);
    cyc();
    neg(); chk("w_valid", out_valid, 1); chk("w_pc", out_pc, 32'hFFFF_FFFC);
    chk("w_pc4", out_pc_plus_4, 32'h0000_0000);
    repeat (4) cyc();

    // Asynchronous reset mid-stream with three entries queued
    do_reset(1, 0);
    expect_seq(32'h0040_0000, 64);
    mon_en = 1;
    repeat (4) cyc();
    chk("ar_count_pre", DEBUG_count, 3);
    #1 mon_en = 0; reset = 1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_req", imem_req, 0);
    chk("ar_count", DEBUG_count, 0);
    do_reset(1, 1);
    expect_seq(32'h0040_0000, 64);
    mon_en = 1;
    neg(); chk("ar_req0", imem_req, 1); chk("ar_addr0", imem_addr, 32'h0040_0000);
    cyc(); cyc();
    neg(); chk("ar_valid2", out_valid, 1); chk("ar_pc2", out_pc, 32'h0040_0000);
    repeat (4) cyc();

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
